// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out transmitter.
// A WIDTH-bit word is taken through a valid/ready handshake and shifted out
// one bit per clock on sout, qualified by sout_valid. frame_start marks the
// first bit of a frame and done marks the last one. While done is high,
// load_ready is also high, so back-to-back words go out with no idle gap.
// Optional build macro: PISO_SHIFT_TX_PARITY_EN appends an even-parity bit
// after the data bits, so each frame is WIDTH+1 bits long.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,          // async, active low
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
`ifdef PISO_SHIFT_TX_PARITY_EN
  logic             r_par;
`endif

  logic w_accept;
  logic w_last;
  logic w_bit;

  // A word is taken whenever the sender offers one and the block is ready.
  assign w_accept = load_valid & load_ready;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

  // Select the bit currently on the line. The outgoing data bit always sits
  // at the shift-out end of r_shift. The parity bit follows the data bits.
  always_comb begin
    w_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
`ifdef PISO_SHIFT_TX_PARITY_EN
    if (r_cnt == CW'(WIDTH)) w_bit = r_par;
`endif
  end

  // State register. The async reset drops any frame that is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic. When a frame ends and no new word is waiting, the
  // block returns to IDLE. Otherwise it stays in SHIFT for the next frame.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture the word on accept, then shift one bit per cycle.
  // The counter is cleared on accept and at frame end, so it never passes N-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_shift <= din;
    end else if (r_state == SHIFT) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      if (MSB_FIRST) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      else           r_shift <= {1'b0, r_shift[WIDTH-1:1]};
    end
  end

`ifdef PISO_SHIFT_TX_PARITY_EN
  // Even parity over the accepted word, held for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_par <= 1'b0;
    else if (w_accept) r_par <= ^din;
  end
`endif

  // Output decode. Outputs depend only on registered state, so nothing
  // passes combinationally from din or load_valid to an output.
  always_comb begin
    load_ready  = 1'b0;
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        busy        = 1'b1;
        sout_valid  = 1'b1;
        sout        = w_bit;
        frame_start = (r_cnt == '0);
        done        = w_last;
        load_ready  = w_last;
      end
      default: load_ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx. One MSB-first instance (index 1) and one LSB-first
// instance (index 0) run side by side on the same stimulus. A frame-level
// model predicts every output on every cycle. Directed scenarios then pin
// the serial bit patterns to hand-computed literals.
module tb_piso_shift_tx;

  localparam int WIDTH = 8;
`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int N = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int N = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             load_valid = 1'b0;

  logic [1:0] w_load_ready, w_sout, w_sout_valid, w_frame_start, w_done, w_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(w_load_ready[1]), .sout(w_sout[1]), .sout_valid(w_sout_valid[1]),
    .frame_start(w_frame_start[1]), .done(w_done[1]), .busy(w_busy[1]));

  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(w_load_ready[0]), .sout(w_sout[0]), .sout_valid(w_sout_valid[0]),
    .frame_start(w_frame_start[0]), .done(w_done[0]), .busy(w_busy[0]));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is the list of bits in send order. rem is the number of
  // bits still to appear on the line, counting the one being shown now.
  function automatic logic [N-1:0] build(input logic [WIDTH-1:0] d, input bit msb);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s[i] = msb ? d[WIDTH-1-i] : d[i];
`ifdef PISO_SHIFT_TX_PARITY_EN
    s[N-1] = ^d;
`endif
    return s;
  endfunction

  int           rem [2] = '{0, 0};
  logic [N-1:0] seq [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 2; j++) rem[j] <= 0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (load_valid && rem[j] <= 1) begin
          seq[j] <= build(din, j == 1);
          rem[j] <= N;
        end else if (rem[j] > 0) begin
          rem[j] <= rem[j] - 1;
        end
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      logic act_bit;
      act_bit = (rem[j] > 0) ? seq[j][N - rem[j]] : 1'b0;
      check($sformatf("sout[%0d]", j),        64'(w_sout[j]),        64'(act_bit));
      check($sformatf("sout_valid[%0d]", j),  64'(w_sout_valid[j]),  64'(rem[j] > 0));
      check($sformatf("busy[%0d]", j),        64'(w_busy[j]),        64'(rem[j] > 0));
      check($sformatf("frame_start[%0d]", j), 64'(w_frame_start[j]), 64'(rem[j] == N));
      check($sformatf("done[%0d]", j),        64'(w_done[j]),        64'(rem[j] == 1));
      check($sformatf("load_ready[%0d]", j),  64'(w_load_ready[j]),  64'(rem[j] <= 1));
    end
  end

  // Offer one word for a single cycle. The task returns at the falling edge
  // where the first bit of the frame is on the line.
  task automatic start(input logic [7:0] d);
    load_valid = 1'b1;
    din = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Record n cycles of line activity starting at the current falling edge.
  // Optionally raise load_valid (with din=d2) at index set_at and drop it at index clr_at.
  task automatic capture(input int n, input int set_at, input logic [7:0] d2, input int clr_at,
                         output logic [63:0] bm, output logic [63:0] bl,
                         output int nv, output int nfs, output int ndn);
    bm = '0; bl = '0; nv = 0; nfs = 0; ndn = 0;
    for (int i = 0; i < n; i++) begin
      bm = {bm[62:0], w_sout[1]};
      bl = {bl[62:0], w_sout[0]};
      if (w_sout_valid[1]) nv++;
      if (w_frame_start[1]) nfs++;
      if (w_done[1]) ndn++;
      if (i == set_at) begin load_valid = 1'b1; din = d2; end
      if (i == clr_at) load_valid = 1'b0;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] bm, bl;
    int nv, nfs, ndn;

    // Reset held low with a valid word offered: nothing may be taken.
    load_valid = 1'b1;
    din = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_load_ready", 64'(w_load_ready), 64'h3);
      check("rst_busy",       64'(w_busy),       64'h0);
      check("rst_sout_valid", 64'(w_sout_valid), 64'h0);
      check("rst_sout",       64'(w_sout),       64'h0);
    end
    load_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'(w_sout_valid), 64'h0);

    // Single frame A5.
    start(8'hA5);
    capture(N, -1, 8'h00, -1, bm, bl, nv, nfs, ndn);
    check("a5_msb_bits", bm & ((64'd1 << N) - 1), PAR ? 64'h14A : 64'hA5);
    check("a5_lsb_bits", bl & ((64'd1 << N) - 1), PAR ? 64'h14A : 64'hA5);
    check("a5_valid_cnt", 64'(nv), 64'(N));
    check("a5_fs_cnt",    64'(nfs), 64'd1);
    check("a5_done_cnt",  64'(ndn), 64'd1);
    @(negedge clk);
    check("a5_idle_after", 64'(w_sout_valid), 64'h0);

    // Back-to-back: 3C followed by C3, with load_valid held through the first frame.
    start(8'h3C);
    capture(2 * N, 0, 8'hC3, N, bm, bl, nv, nfs, ndn);
    check("b2b_msb_bits", bm & ((64'd1 << (2 * N)) - 1), PAR ? 64'hF186 : 64'h3CC3);
    check("b2b_lsb_bits", bl & ((64'd1 << (2 * N)) - 1), PAR ? 64'hF186 : 64'h3CC3);
    check("b2b_valid_cnt", 64'(nv), 64'(2 * N));
    check("b2b_fs_cnt",    64'(nfs), 64'd2);
    check("b2b_done_cnt",  64'(ndn), 64'd2);
    @(negedge clk);
    check("b2b_idle_after", 64'(w_busy), 64'h0);

    // Word 01, with a second word FF offered mid-frame; FF must be ignored.
    start(8'h01);
    capture(N, 1, 8'hFF, N - 1, bm, bl, nv, nfs, ndn);
    check("ign_msb_bits", bm & ((64'd1 << N) - 1), PAR ? 64'h03 : 64'h01);
    check("ign_lsb_bits", bl & ((64'd1 << N) - 1), PAR ? 64'h101 : 64'h80);
    check("ign_fs_cnt", 64'(nfs), 64'd1);
    @(negedge clk);
    check("ign_idle_after", 64'(w_busy), 64'h0);

    // Asynchronous reset asserted during bit 4 of F0.
    start(8'hF0);
    capture(5, -1, 8'h00, -1, bm, bl, nv, nfs, ndn);
    check("f0_partial_msb", bm & 64'h1F, 64'h1E);
    #2 rst = 1'b0;
    #1;
    check("async_sout_valid", 64'(w_sout_valid), 64'h0);
    check("async_busy",       64'(w_busy),       64'h0);
    check("async_load_ready", 64'(w_load_ready), 64'h3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start(8'h81);
    capture(N, -1, 8'h00, -1, bm, bl, nv, nfs, ndn);
    check("r81_msb_bits", bm & ((64'd1 << N) - 1), PAR ? 64'h102 : 64'h81);
    check("r81_lsb_bits", bl & ((64'd1 << N) - 1), PAR ? 64'h102 : 64'h81);
    check("r81_fs_cnt", 64'(nfs), 64'd1);
    @(negedge clk);

`ifdef PISO_SHIFT_TX_PARITY_EN
    // Parity: 07 has three ones, so its parity bit is 1.
    start(8'h07);
    capture(N, -1, 8'h00, -1, bm, bl, nv, nfs, ndn);
    check("p07_msb_bits", bm & 64'h1FF, 64'h00F);
    check("p07_lsb_bits", bl & 64'h1FF, 64'h1C1);
    check("p07_done_cnt", 64'(ndn), 64'd1);
    check("p07_valid_cnt", 64'(nv), 64'd9);
    @(negedge clk);
    // Parity: 03 has two ones, so its parity bit is 0.
    start(8'h03);
    capture(N, -1, 8'h00, -1, bm, bl, nv, nfs, ndn);
    check("p03_msb_bits", bm & 64'h1FF, 64'h006);
    check("p03_lsb_bits", bl & 64'h1FF, 64'h180);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
